// File: rtl/core_c1_trap_ctrl.sv
// core_c1_trap_ctrl: trap sequencer for the c1 core.
// Takes exceptions and interrupts from core_c1_clic and mret from decode.
// It stalls and flushes the pipeline, then updates the mepc, mcause and
// mstatus.{MIE,MPIE} CSRs, which this block owns. It finishes by issuing a
// PC redirect to the trap vector or to mepc.
// Optional build macro TRAP_VECTOR_EN enables vectored interrupt targets
// when mtvec[1:0] == 2'b01. When the macro is undefined, all traps go to
// the mtvec base.
module core_c1_trap_ctrl #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RST_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_in,
    input  logic [7:0]      irq_code,
    input  logic            exc_in,
    input  logic [7:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] next_pc,
    input  logic            mret_in,
    input  logic            pipe_idle,
    input  logic [XLEN-1:0] mtvec,
    input  logic            csr_we_mstatus,
    input  logic [XLEN-1:0] csr_wdata,
    output logic            pipe_stall,
    output logic            pipe_flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic            mstatus_mie,
    output logic            mstatus_mpie,
    output logic            trap_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        SAVE  = 3'd2,
        REDIR = 3'd3,
        MRET  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic            take_exc;
    logic            take_irq;
    logic [7:0]      cause_q;
    logic            is_irq_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    assign trap_base   = {mtvec[XLEN-1:2], 2'b00};
    assign redirect_pc = target_q;
    assign trap_busy   = (state != IDLE);

    // Trap destination: mtvec base, optionally offset by the interrupt cause.
    always_comb begin
        trap_target = trap_base;
`ifdef TRAP_VECTOR_EN
        if (is_irq_q && (mtvec[1:0] == 2'b01))
            trap_target = trap_base + {{(XLEN-10){1'b0}}, cause_q, 2'b00};
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and pipeline controls. Requests are sampled only in IDLE.
    always_comb begin
        state_nx       = state;
        pipe_stall     = 1'b0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        take_exc       = 1'b0;
        take_irq       = 1'b0;
        case (state)
            IDLE: begin
                if (exc_in) begin
                    take_exc = 1'b1;
                    state_nx = FLUSH;
                end else if (irq_in && mstatus_mie) begin
                    take_irq = 1'b1;
                    state_nx = FLUSH;
                end else if (mret_in) begin
                    state_nx = MRET;
                end
            end
            FLUSH: begin
                pipe_stall = 1'b1;
                pipe_flush = 1'b1;
                if (pipe_idle)
                    state_nx = SAVE;
            end
            SAVE: begin
                pipe_stall = 1'b1;
                state_nx   = REDIR;
            end
            REDIR: begin
                pipe_stall     = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready)
                    state_nx = IDLE;
            end
            MRET: begin
                pipe_flush = 1'b1;
                state_nx   = REDIR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Trap context latch, CSR updates and redirect target register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q      <= '0;
            is_irq_q     <= 1'b0;
            epc_q        <= '0;
            target_q     <= '0;
            mepc         <= {RST_VECTOR[XLEN-1:2], 2'b00};
            mcause       <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_exc) begin
                        cause_q  <= exc_code;
                        is_irq_q <= 1'b0;
                        epc_q    <= exc_pc;
                    end else if (take_irq) begin
                        cause_q  <= irq_code;
                        is_irq_q <= 1'b1;
                        epc_q    <= next_pc;
                    end else if (csr_we_mstatus) begin
                        // A trap taken in the same cycle drops this write.
                        mstatus_mie  <= csr_wdata[3];
                        mstatus_mpie <= csr_wdata[7];
                    end
                end
                SAVE: begin
                    mepc         <= {epc_q[XLEN-1:2], 2'b00};
                    mcause       <= {is_irq_q, {(XLEN-9){1'b0}}, cause_q};
                    mstatus_mpie <= mstatus_mie;
                    mstatus_mie  <= 1'b0;
                    target_q     <= trap_target;
                end
                MRET: begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                    target_q     <= mepc;
                end
                default: ;
            endcase
        end
    end

    // Bits that are intentionally not consumed.
    logic unused_bits;
`ifdef TRAP_VECTOR_EN
    assign unused_bits = ^{csr_wdata[XLEN-1:8], csr_wdata[6:4], csr_wdata[2:0],
                           epc_q[1:0]};
`else
    assign unused_bits = ^{csr_wdata[XLEN-1:8], csr_wdata[6:4], csr_wdata[2:0],
                           epc_q[1:0], mtvec[1:0]};
`endif

endmodule

// File: tb/tb_core_c1_trap_ctrl.sv
// Testbench for core_c1_trap_ctrl. Expected redirects and the CSR values
// that go with them are pushed to a queue when stimulus is driven. They
// are popped and compared when the DUT presents a redirect.
module tb_core_c1_trap_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic        mie;
        logic        mpie;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_in;
    logic [7:0]  irq_code;
    logic        exc_in;
    logic [7:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] next_pc;
    logic        mret_in;
    logic        pipe_idle;
    logic [31:0] mtvec;
    logic        csr_we_mstatus;
    logic [31:0] csr_wdata;
    logic        pipe_stall;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        trap_busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // reference model of the CSRs
    logic        m_mie, m_mpie;
    logic [31:0] m_mepc, m_mcause;

    localparam logic [31:0] RSTV = 32'h0000_1000;

    core_c1_trap_ctrl #(.XLEN(32), .RST_VECTOR(RSTV)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_code(irq_code),
        .exc_in(exc_in), .exc_code(exc_code), .exc_pc(exc_pc), .next_pc(next_pc),
        .mret_in(mret_in), .pipe_idle(pipe_idle), .mtvec(mtvec),
        .csr_we_mstatus(csr_we_mstatus), .csr_wdata(csr_wdata),
        .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .mepc(mepc), .mcause(mcause),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .trap_busy(trap_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_redir(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!redirect_valid && n < 50);
    endtask

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_mepc = RSTV; m_mcause = 32'h0;
    endtask

    function automatic logic [31:0] vec_target(input logic irq, input logic [7:0] code,
                                               input logic [31:0] tvec);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
`ifdef TRAP_VECTOR_EN
        if (irq && tvec[1:0] == 2'b01)
            return base + {22'b0, code, 2'b00};
`endif
        return base;
    endfunction

    task automatic push_trap(input logic irq, input logic [7:0] code, input logic [31:0] epc);
        exp_t e;
        e.pc     = vec_target(irq, code, mtvec);
        e.mepc   = epc & ~32'h3;
        e.mcause = {irq, 23'b0, code};
        e.mpie   = m_mie;
        e.mie    = 1'b0;
        sb.push_back(e);
        m_mepc = e.mepc; m_mcause = e.mcause; m_mpie = e.mpie; m_mie = e.mie;
    endtask

    task automatic push_mret();
        exp_t e;
        e.pc     = m_mepc;
        e.mepc   = m_mepc;
        e.mcause = m_mcause;
        e.mie    = m_mpie;
        e.mpie   = 1'b1;
        sb.push_back(e);
        m_mie = e.mie; m_mpie = e.mpie;
    endtask

    task automatic test_reset();
        logic [101:0] got, exp;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        got = {pipe_stall, pipe_flush, redirect_valid, trap_busy, redirect_pc, mepc,
               mcause, mstatus_mie, mstatus_mpie};
        exp = {4'b0000, 32'h0, RSTV, 32'h0, 2'b00};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_exc_basic();
        exp_t e, got;
        mtvec = 32'h200;
        exc_in = 1'b1; exc_code = 8'd2; exc_pc = 32'h104;
        push_trap(1'b0, 8'd2, 32'h104);
        tick();
        exc_in = 1'b0;
        total++;
        if ({trap_busy, pipe_stall, pipe_flush, redirect_valid} !== 4'b1110) begin
            bad++;
            $display("FAIL exc_flush_n1 got=%b exp=1110",
                     {trap_busy, pipe_stall, pipe_flush, redirect_valid});
        end
        tick();
        total++;
        if ({trap_busy, pipe_stall, pipe_flush, redirect_valid, mepc} !== {4'b1100, RSTV}) begin
            bad++;
            $display("FAIL exc_save_n2 got=%b mepc=%h exp=1100 mepc=%h",
                     {trap_busy, pipe_stall, pipe_flush, redirect_valid}, mepc, RSTV);
        end
        tick();
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL exc_redir_n3 redirect_valid=%b exp=1", redirect_valid);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL exc_redir_n3 got=%h exp=%h", got, e);
            end
        end
        tick();
        total++;
        if ({trap_busy, pipe_stall, redirect_valid} !== 3'b000) begin
            bad++;
            $display("FAIL exc_return_idle got=%b exp=000",
                     {trap_busy, pipe_stall, redirect_valid});
        end
    endtask

    task automatic test_irq_mret();
        exp_t e, got;
        int n;
        csr_we_mstatus = 1'b1; csr_wdata = 32'h8;
        tick();
        csr_we_mstatus = 1'b0;
        m_mie = 1'b1; m_mpie = 1'b0;
        total++;
        if ({mstatus_mie, mstatus_mpie} !== 2'b10) begin
            bad++;
            $display("FAIL csr_write got=%b exp=10", {mstatus_mie, mstatus_mpie});
        end
        irq_in = 1'b1; irq_code = 8'd7; next_pc = 32'h88;
        push_trap(1'b1, 8'd7, 32'h88);
        tick();
        irq_in = 1'b0;
        wait_redir(n);
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL irq_redir no redirect after %0d cycles", n);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL irq_redir got=%h exp=%h", got, e);
            end
        end
        tick();
        mret_in = 1'b1;
        push_mret();
        tick();
        mret_in = 1'b0;
        total++;
        if ({trap_busy, pipe_stall, pipe_flush, redirect_valid} !== 4'b1010) begin
            bad++;
            $display("FAIL mret_state got=%b exp=1010",
                     {trap_busy, pipe_stall, pipe_flush, redirect_valid});
        end
        wait_redir(n);
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL mret_redir no redirect after %0d cycles", n);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL mret_redir got=%h exp=%h", got, e);
            end
        end
        tick();
    endtask

    task automatic test_priority();
        exp_t e, got;
        int n;
        exc_in = 1'b1; exc_code = 8'd11; exc_pc = 32'h300;
        irq_in = 1'b1; irq_code = 8'd3; next_pc = 32'h400;
        push_trap(1'b0, 8'd11, 32'h300);
        tick();
        exc_in = 1'b0;
        wait_redir(n);
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL prio_exc_redir no redirect after %0d cycles", n);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL prio_exc_redir got=%h exp=%h", got, e);
            end
        end
        tick(); tick(); tick(); tick();
        total++;
        if (trap_busy !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked trap_busy=%b exp=0", trap_busy);
        end
        mret_in = 1'b1;
        push_mret();
        push_trap(1'b1, 8'd3, 32'h400);
        tick();
        mret_in = 1'b0;
        wait_redir(n);
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL prio_mret_redir no redirect after %0d cycles", n);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL prio_mret_redir got=%h exp=%h", got, e);
            end
        end
        wait_redir(n);
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL pending_irq_redir no redirect after %0d cycles", n);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL pending_irq_redir got=%h exp=%h", got, e);
            end
        end
        irq_in = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        exp_t e, got;
        logic [31:0] want_pc;
        pipe_idle = 1'b0; redirect_ready = 1'b0;
        exc_in = 1'b1; exc_code = 8'd2; exc_pc = 32'h507;
        push_trap(1'b0, 8'd2, 32'h507);
        want_pc = sb[sb.size()-1].pc;
        tick();
        exc_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({trap_busy, pipe_stall, pipe_flush, redirect_valid} !== 4'b1110) begin
                bad++;
                $display("FAIL flush_hold cycle %0d got=%b exp=1110", i,
                         {trap_busy, pipe_stall, pipe_flush, redirect_valid});
            end
            if (i < 4) tick();
        end
        pipe_idle = 1'b1;
        tick();
        total++;
        if ({trap_busy, pipe_stall, pipe_flush, redirect_valid} !== 4'b1100) begin
            bad++;
            $display("FAIL stall_save got=%b exp=1100",
                     {trap_busy, pipe_stall, pipe_flush, redirect_valid});
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({trap_busy, pipe_stall, pipe_flush, redirect_valid, redirect_pc} !==
                {4'b1101, want_pc}) begin
                bad++;
                $display("FAIL redir_hold cycle %0d got=%b pc=%h exp=1101 pc=%h", i,
                         {trap_busy, pipe_stall, pipe_flush, redirect_valid}, redirect_pc, want_pc);
            end
            tick();
        end
        redirect_ready = 1'b1;
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL stall_redir redirect_valid=%b exp=1", redirect_valid);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL stall_redir got=%h exp=%h", got, e);
            end
        end
        tick();
        total++;
        if ({trap_busy, pipe_stall, redirect_valid} !== 3'b000) begin
            bad++;
            $display("FAIL stall_release got=%b exp=000", {trap_busy, pipe_stall, redirect_valid});
        end
    endtask

    task automatic test_csr_collision();
        exp_t e, got;
        int n;
        csr_we_mstatus = 1'b1; csr_wdata = 32'h88;
        exc_in = 1'b1; exc_code = 8'd3; exc_pc = 32'h600;
        push_trap(1'b0, 8'd3, 32'h600);
        tick();
        exc_in = 1'b0;
        wait_redir(n);
        csr_we_mstatus = 1'b0;
        total++;
        if (!redirect_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL collide_redir no redirect after %0d cycles", n);
        end else begin
            e = sb.pop_front();
            got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
            if (got !== e) begin
                bad++;
                $display("FAIL collide_redir got=%h exp=%h", got, e);
            end
        end
        tick();
        total++;
        if ({mstatus_mie, mstatus_mpie} !== {m_mie, m_mpie}) begin
            bad++;
            $display("FAIL csr_dropped got=%b exp=%b", {mstatus_mie, mstatus_mpie}, {m_mie, m_mpie});
        end
        csr_we_mstatus = 1'b1; csr_wdata = 32'h80;
        tick();
        csr_we_mstatus = 1'b0;
        m_mie = 1'b0; m_mpie = 1'b1;
        total++;
        if ({mstatus_mie, mstatus_mpie} !== 2'b01) begin
            bad++;
            $display("FAIL csr_write_mpie got=%b exp=01", {mstatus_mie, mstatus_mpie});
        end
    endtask

    task automatic test_reset_mid();
        logic [101:0] got, exp;
        exp = {4'b0000, 32'h0, RSTV, 32'h0, 2'b00};
        exc_in = 1'b1; exc_code = 8'd2; exc_pc = 32'h700;
        tick();
        exc_in = 1'b0;
        tick();
        total++;
        if ({trap_busy, pipe_stall, pipe_flush, redirect_valid} !== 4'b1100) begin
            bad++;
            $display("FAIL rst_pre_save got=%b exp=1100",
                     {trap_busy, pipe_stall, pipe_flush, redirect_valid});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        got = {pipe_stall, pipe_flush, redirect_valid, trap_busy, redirect_pc, mepc,
               mcause, mstatus_mie, mstatus_mpie};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL rst_in_save got=%h exp=%h", got, exp);
        end
        redirect_ready = 1'b0;
        exc_in = 1'b1; exc_pc = 32'h704;
        tick();
        exc_in = 1'b0;
        tick(); tick();
        total++;
        if (redirect_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_redir redirect_valid=%b exp=1", redirect_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        redirect_ready = 1'b1;
        got = {pipe_stall, pipe_flush, redirect_valid, trap_busy, redirect_pc, mepc,
               mcause, mstatus_mie, mstatus_mpie};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL rst_in_redir got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_vector();
        exp_t e, got;
        int n;
        logic [31:0] tvecs [2] = '{32'h0000_0201, 32'hFFFF_FFFD};
        for (int k = 0; k < 2; k++) begin
            mtvec = tvecs[k];
            csr_we_mstatus = 1'b1; csr_wdata = 32'h8;
            tick();
            csr_we_mstatus = 1'b0;
            m_mie = 1'b1; m_mpie = 1'b0;
            irq_in = 1'b1; irq_code = 8'd11; next_pc = 32'h800 + k;
            push_trap(1'b1, 8'd11, 32'h800 + k);
            tick();
            irq_in = 1'b0;
            wait_redir(n);
            total++;
            if (!redirect_valid || sb.size() == 0) begin
                bad++;
                $display("FAIL vec_irq_redir[%0d] no redirect after %0d cycles", k, n);
            end else begin
                e = sb.pop_front();
                got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
                if (got !== e) begin
                    bad++;
                    $display("FAIL vec_irq_redir[%0d] got=%h exp=%h", k, got, e);
                end
            end
            tick();
            exc_in = 1'b1; exc_code = 8'd2; exc_pc = 32'h900;
            push_trap(1'b0, 8'd2, 32'h900);
            tick();
            exc_in = 1'b0;
            wait_redir(n);
            total++;
            if (!redirect_valid || sb.size() == 0) begin
                bad++;
                $display("FAIL vec_exc_redir[%0d] no redirect after %0d cycles", k, n);
            end else begin
                e = sb.pop_front();
                got = {redirect_pc, mepc, mcause, mstatus_mie, mstatus_mpie};
                if (got !== e) begin
                    bad++;
                    $display("FAIL vec_exc_redir[%0d] got=%h exp=%h", k, got, e);
                end
            end
            tick();
        end
        mtvec = 32'h200;
    endtask

    initial begin
        rst = 1'b1; irq_in = 1'b0; irq_code = '0; exc_in = 1'b0; exc_code = '0;
        exc_pc = '0; next_pc = '0; mret_in = 1'b0; pipe_idle = 1'b1;
        mtvec = 32'h200; csr_we_mstatus = 1'b0; csr_wdata = '0; redirect_ready = 1'b1;
        model_reset();
        test_reset();
        test_exc_basic();
        test_irq_mret();
        test_priority();
        test_stall();
        test_csr_collision();
        test_reset_mid();
        test_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
